// File: rtl/onehot_stim_feeder.sv
// Serialises a captured parallel pattern MSB-first onto w, holding each bit
// for TICK_DIV clocks. One-hot IDLE/SHIFT/DONE control with a one-cycle done pulse.
module onehot_stim_feeder #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic             hold,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       o_dbg_state
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_SHIFT = 3'b010,
    S_DONE  = 3'b100
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [BIT_W-1:0] r_bitcnt;
  logic [DIV_W-1:0] r_divcnt;

  logic w_div_last;
  logic w_bit_last;
  logic w_advance;

  assign w_div_last = (r_divcnt == DIV_LAST);
  assign w_bit_last = (r_bitcnt == BIT_LAST);
  // A shift-state cycle only counts toward the bit period when not paused.
  assign w_advance  = (r_state == S_SHIFT) && !hold;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_advance && w_div_last && w_bit_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_divcnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && start) begin
        r_shreg  <= pattern;
        r_bitcnt <= '0;
        r_divcnt <= '0;
      end else if (w_advance) begin
        if (w_div_last) begin
          r_divcnt <= '0;
          r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
          // Bit counter returns to zero after the last bit instead of wrapping.
          r_bitcnt <= w_bit_last ? '0 : r_bitcnt + BIT_W'(1);
        end else begin
          r_divcnt <= r_divcnt + DIV_W'(1);
        end
      end
    end
  end

  assign w           = (r_state == S_SHIFT) ? r_shreg[WIDTH-1] : 1'b0;
  assign w_valid     = w_advance;
  assign busy        = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign done        = (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_onehot_stim_feeder.sv
// Directed bench for onehot_stim_feeder: one instance at TICK_DIV=1 and one at
// TICK_DIV=3, both WIDTH=8, sharing clock, reset, pattern and hold.
module tb_onehot_stim_feeder;

  logic       clock;
  logic       reset;
  logic       start1;
  logic       start3;
  logic [7:0] pattern;
  logic       hold;

  logic       w1, v1, b1, d1;
  logic       w3, v3, b3, d3;
  logic [2:0] st1, st3;

  int checks;
  int failures;

  onehot_stim_feeder #(.WIDTH(8), .TICK_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .pattern(pattern), .hold(hold),
    .w(w1), .w_valid(v1), .busy(b1), .done(d1), .o_dbg_state(st1)
  );

  onehot_stim_feeder #(.WIDTH(8), .TICK_DIV(3)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .pattern(pattern), .hold(hold),
    .w(w3), .w_valid(v3), .busy(b3), .done(d3), .o_dbg_state(st3)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // advance one cycle; inputs change and outputs are sampled at the negedge
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // w, w_valid, busy, done of the TICK_DIV=1 instance
  task automatic check1(input string tag, input logic ew, input logic ev,
                        input logic eb, input logic ed);
    check({tag, ".w"},       {7'd0, w1}, {7'd0, ew});
    check({tag, ".w_valid"}, {7'd0, v1}, {7'd0, ev});
    check({tag, ".busy"},    {7'd0, b1}, {7'd0, eb});
    check({tag, ".done"},    {7'd0, d1}, {7'd0, ed});
  endtask

  task automatic check3(input string tag, input logic ew, input logic ev,
                        input logic eb, input logic ed);
    check({tag, ".w"},       {7'd0, w3}, {7'd0, ew});
    check({tag, ".w_valid"}, {7'd0, v3}, {7'd0, ev});
    check({tag, ".busy"},    {7'd0, b3}, {7'd0, eb});
    check({tag, ".done"},    {7'd0, d3}, {7'd0, ed});
  endtask

  initial begin
    logic [7:0]  exp_pat;
    logic [10:0] exp_w_hold;
    logic [10:0] exp_v_hold;
    checks   = 0;
    failures = 0;
    hold     = 1'b0;
    pattern  = 8'h00;

    // 1. reset held two cycles with start high on both instances
    reset  = 1'b1;
    start1 = 1'b1;
    start3 = 1'b1;
    tick();
    tick();
    check1("rst1", 1'b0, 1'b0, 1'b0, 1'b0);
    check3("rst3", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst1.state", {5'd0, st1}, 8'h01);
    reset  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    tick();
    check1("post_rst1", 1'b0, 1'b0, 1'b0, 1'b0);

    // 2. basic run, pattern 0011_0110, TICK_DIV=1
    exp_pat = 8'b0011_0110;
    pattern = exp_pat;
    start1  = 1'b1;
    tick();
    start1  = 1'b0;
    pattern = 8'hFF;  // changing pattern after capture must not matter
    for (int i = 0; i < 8; i++) begin
      check1($sformatf("basic.c%0d", i + 1), exp_pat[7 - i], 1'b1, 1'b1, 1'b0);
      if (i == 0) check("basic.state", {5'd0, st1}, 8'h02);
      tick();
    end
    check1("basic.c9", 1'b0, 1'b0, 1'b1, 1'b1);
    check("basic.state_done", {5'd0, st1}, 8'h04);
    tick();
    check1("basic.c10", 1'b0, 1'b0, 1'b0, 1'b0);

    // 3. divider, pattern A5, TICK_DIV=3: done on cycle 25
    exp_pat = 8'hA5;
    pattern = exp_pat;
    start3  = 1'b1;
    tick();
    start3  = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      check3($sformatf("div.c%0d", c), exp_pat[7 - ((c - 1) / 3)], 1'b1, 1'b1, 1'b0);
      tick();
    end
    check3("div.c25", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check3("div.c26", 1'b0, 1'b0, 1'b0, 1'b0);

    // 4. hold during cycles 3-5, pattern F0: done delayed to cycle 12
    exp_w_hold = 11'b111_1111_0000;
    exp_v_hold = 11'b110_0011_1111;
    pattern = 8'hF0;
    start1  = 1'b1;
    tick();
    start1  = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      hold = (c >= 3 && c <= 5);
      #1;
      check1($sformatf("hold.c%0d", c), exp_w_hold[11 - c], exp_v_hold[11 - c], 1'b1, 1'b0);
      tick();
    end
    hold = 1'b0;
    check1("hold.c12", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check1("hold.c13", 1'b0, 1'b0, 1'b0, 1'b0);

    // 5. start while busy is ignored; start on first IDLE cycle is accepted
    exp_pat = 8'hC3;
    pattern = exp_pat;
    start1  = 1'b1;
    tick();
    start1  = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 4) begin
        start1  = 1'b1;
        pattern = 8'h00;
      end else begin
        start1  = 1'b0;
      end
      check1($sformatf("busy_start.c%0d", c), exp_pat[8 - c], 1'b1, 1'b1, 1'b0);
      tick();
    end
    start1  = 1'b1;  // start during DONE
    pattern = 8'h00;
    check1("busy_start.c9", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    exp_pat = 8'h81;
    pattern = exp_pat;  // start on the IDLE cycle after DONE
    check1("busy_start.c10", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    start1  = 1'b0;
    for (int c = 11; c <= 18; c++) begin
      check1($sformatf("rerun.c%0d", c), exp_pat[18 - c], 1'b1, 1'b1, 1'b0);
      tick();
    end
    check1("rerun.c19", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();

    // 6. reset at cycle 5 of an FF run: clean abort, no done pulse
    pattern = 8'hFF;
    start1  = 1'b1;
    tick();
    start1  = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check1($sformatf("abort.c%0d", c), 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check1("abort.c6", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 7; c <= 12; c++) begin
      tick();
      check1($sformatf("abort.c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    exp_pat = 8'h5A;
    pattern = exp_pat;
    start1  = 1'b1;
    tick();
    start1  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check1($sformatf("after_rst.c%0d", i + 1), exp_pat[7 - i], 1'b1, 1'b1, 1'b0);
      tick();
    end
    check1("after_rst.c9", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check1("after_rst.c10", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
